// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared FSM encoding and BCD constants for the score accumulator
package score_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'h9;

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - single-digit BCD adder with carry in/out
module bcd_digit_add
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             ci,
  output logic [BCD_W-1:0] s,
  output logic             co
);

  logic [BCD_W:0] raw;
  logic [BCD_W:0] adj;

  // Binary sum above 9 is corrected by +6 to wrap into the next decade.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, ci};
    co  = (raw > 5'd9);
    adj = co ? (raw + 5'd6) : raw;
    s   = adj[BCD_W-1:0];
  end

endmodule

// File: rtl/score_accumulator.sv
// rtl/score_accumulator.sv - BCD score accumulator with combo multiplier and high score
module score_accumulator
  import score_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int COMBO_W    = 4,
  parameter int COMBO_STEP = 4,
  parameter int MAX_MULT   = 4
) (
  input  logic                    C,
  input  logic                    INIT_N,
  input  logic                    CLR,
  input  logic                    HIT,
  input  logic                    MISS,
  input  logic [3:0]              PTS,
  output logic [BCD_W*DIGITS-1:0] SCORE,
  output logic [BCD_W*DIGITS-1:0] HIGH,
  output logic [COMBO_W-1:0]      COMBO,
  output logic [2:0]              MULT,
  output logic                    BUSY,
  output logic                    DROP,
  output logic                    OVF
);

  localparam int SW = BCD_W * DIGITS;

  state_t            state, state_nxt;
  logic [BCD_W-1:0]  pts_q;
  logic [2:0]        rpt_q;
  logic [SW-1:0]     sum;
  logic [DIGITS:0]   carry;
  logic [31:0]       mult_raw;
  logic              accept;

  assign mult_raw = 32'(COMBO) / 32'(COMBO_STEP) + 32'd1;
  assign MULT     = (mult_raw >= 32'(MAX_MULT)) ? 3'(MAX_MULT) : mult_raw[2:0];
  assign BUSY     = (state != IDLE);
  assign accept   = HIT && !MISS && !CLR && (state == IDLE);

  // Points enter at the least significant digit; upper digits only ripple carries.
  assign carry[0] = 1'b0;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_add u_digit (
      .a  (SCORE[i*BCD_W +: BCD_W]),
      .b  ((i == 0) ? pts_q : {BCD_W{1'b0}}),
      .ci (carry[i]),
      .s  (sum[i*BCD_W +: BCD_W]),
      .co (carry[i+1])
    );
  end

  always_ff @(posedge C or negedge INIT_N) begin
    if (!INIT_N) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (rpt_q <= 3'd1) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (CLR) state_nxt = IDLE;
  end

  always_ff @(posedge C or negedge INIT_N) begin
    if (!INIT_N) begin
      SCORE <= '0;
      HIGH  <= '0;
      COMBO <= '0;
      OVF   <= 1'b0;
      DROP  <= 1'b0;
      pts_q <= '0;
      rpt_q <= '0;
    end else if (CLR) begin
      SCORE <= '0;
      COMBO <= '0;
      OVF   <= 1'b0;
      DROP  <= 1'b0;
    end else begin
      DROP <= HIT && BUSY;
      if (MISS)                        COMBO <= '0;
      else if (accept && COMBO != '1)  COMBO <= COMBO + COMBO_W'(1);
      if (accept) begin
        pts_q <= (PTS > 4'd9) ? BCD_NINE : PTS;
        rpt_q <= MULT;
      end
      if (state == ADD) begin
        rpt_q <= rpt_q - 3'd1;
        // Saturation is sticky: an all-9s score plus any nonzero points carries out again.
        if (carry[DIGITS]) begin
          SCORE <= {DIGITS{BCD_NINE}};
          OVF   <= 1'b1;
        end else begin
          SCORE <= sum;
        end
      end
      if (state == UPDATE && SCORE > HIGH) HIGH <= SCORE;
    end
  end

endmodule

// File: tb/tb_score_accumulator.sv
// tb/tb_score_accumulator.sv - directed self-checking bench for score_accumulator
module tb_score_accumulator;

  logic        C = 1'b0;
  logic        INIT_N = 1'b0;
  logic        clr_a = 0, hit_a = 0, miss_a = 0;
  logic [3:0]  pts_a = 0;
  logic [15:0] score_a, high_a;
  logic [3:0]  combo_a;
  logic [2:0]  mult_a;
  logic        busy_a, drop_a, ovf_a;

  logic        clr_b = 0, hit_b = 0, miss_b = 0;
  logic [3:0]  pts_b = 0;
  logic [7:0]  score_b, high_b;
  logic [3:0]  combo_b;
  logic [2:0]  mult_b;
  logic        busy_b, drop_b, ovf_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 C = ~C;

  score_accumulator dut_a (
    .C(C), .INIT_N(INIT_N), .CLR(clr_a), .HIT(hit_a), .MISS(miss_a), .PTS(pts_a),
    .SCORE(score_a), .HIGH(high_a), .COMBO(combo_a), .MULT(mult_a),
    .BUSY(busy_a), .DROP(drop_a), .OVF(ovf_a)
  );

  score_accumulator #(.DIGITS(2)) dut_b (
    .C(C), .INIT_N(INIT_N), .CLR(clr_b), .HIT(hit_b), .MISS(miss_b), .PTS(pts_b),
    .SCORE(score_b), .HIGH(high_b), .COMBO(combo_b), .MULT(mult_b),
    .BUSY(busy_b), .DROP(drop_b), .OVF(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hit(input bit b, input logic [3:0] p);
    @(negedge C);
    if (b) begin hit_b = 1; pts_b = p; end
    else   begin hit_a = 1; pts_a = p; end
    @(negedge C);
    hit_a = 0;
    hit_b = 0;
  endtask

  task automatic pulse_miss(input bit b);
    @(negedge C);
    if (b) miss_b = 1; else miss_a = 1;
    @(negedge C);
    miss_a = 0;
    miss_b = 0;
  endtask

  task automatic pulse_clr(input bit b);
    @(negedge C);
    if (b) clr_b = 1; else clr_a = 1;
    @(negedge C);
    clr_a = 0;
    clr_b = 0;
  endtask

  task automatic wait_idle(input bit b);
    for (int i = 0; i < 20 && (b ? busy_b : busy_a); i++) @(negedge C);
    chk("idle_timeout", {31'd0, (b ? busy_b : busy_a)}, 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_score", score_a, 0);
    chk("rst_high",  high_a, 0);
    chk("rst_combo", combo_a, 0);
    chk("rst_mult",  mult_a, 1);
    chk("rst_busy",  busy_a, 0);
    chk("rst_drop",  drop_a, 0);
    chk("rst_ovf",   ovf_a, 0);
    @(negedge C);
    INIT_N = 1;

    // single hit, multiplier 1
    hit(0, 4'd5);
    chk("h1_busy_add", busy_a, 1);
    chk("h1_combo", combo_a, 1);
    @(negedge C);
    chk("h1_score", score_a, 16'h0005);
    chk("h1_busy_upd", busy_a, 1);
    chk("h1_high_pre", high_a, 0);
    @(negedge C);
    chk("h1_high", high_a, 16'h0005);
    chk("h1_busy_done", busy_a, 0);

    // combo climbs to the 2x multiplier
    pulse_clr(0);
    chk("clr_high_kept", high_a, 16'h0005);
    for (int i = 0; i < 4; i++) begin
      hit(0, 4'd3);
      wait_idle(0);
    end
    chk("c4_score", score_a, 16'h0012);
    chk("c4_mult", mult_a, 2);
    hit(0, 4'd3);
    @(negedge C);
    chk("c5_mid", score_a, 16'h0015);
    @(negedge C);
    chk("c5_score", score_a, 16'h0018);
    wait_idle(0);
    chk("c5_combo", combo_a, 5);
    chk("c5_high", high_a, 16'h0018);

    // hit during ADD is dropped
    hit(0, 4'd2);
    hit_a = 1;
    @(negedge C);
    hit_a = 0;
    chk("drop_pulse", drop_a, 1);
    chk("drop_score_mid", score_a, 16'h0020);
    chk("drop_combo", combo_a, 6);
    @(negedge C);
    chk("drop_clear", drop_a, 0);
    chk("drop_score", score_a, 16'h0022);
    wait_idle(0);
    chk("drop_final", score_a, 16'h0022);

    // hit and miss together: miss wins
    @(negedge C);
    hit_a = 1; miss_a = 1; pts_a = 4'd9;
    @(negedge C);
    hit_a = 0; miss_a = 0;
    chk("hm_score", score_a, 16'h0022);
    chk("hm_combo", combo_a, 0);
    chk("hm_busy", busy_a, 0);
    chk("hm_drop", drop_a, 0);

    // clear keeps the high score
    hit(0, 4'd9); wait_idle(0);
    hit(0, 4'd9); wait_idle(0);
    hit(0, 4'd2); wait_idle(0);
    chk("s42_score", score_a, 16'h0042);
    chk("s42_high", high_a, 16'h0042);
    pulse_clr(0);
    chk("clr_score", score_a, 0);
    chk("clr_ovf", ovf_a, 0);
    chk("clr_combo", combo_a, 0);
    chk("clr_high", high_a, 16'h0042);
    hit(0, 4'd5); wait_idle(0);
    chk("pc_score", score_a, 16'h0005);
    chk("pc_high", high_a, 16'h0042);

    // zero points still traverse the FSM
    hit(0, 4'd0);
    chk("p0_busy", busy_a, 1);
    wait_idle(0);
    chk("p0_score", score_a, 16'h0005);
    chk("p0_combo", combo_a, 2);

    // asynchronous reset mid-ADD
    hit(0, 4'd3);
    #2 INIT_N = 0;
    #1;
    chk("ar_score", score_a, 0);
    chk("ar_high", high_a, 0);
    chk("ar_combo", combo_a, 0);
    chk("ar_mult", mult_a, 1);
    chk("ar_busy", busy_a, 0);
    @(negedge C);
    INIT_N = 1;
    hit(0, 4'd1); wait_idle(0);
    chk("ar_after", score_a, 16'h0001);

    // two-digit saturation; PTS above 9 clamps to 9
    for (int i = 0; i < 10; i++) begin
      hit(1, 4'hF);
      wait_idle(1);
      pulse_miss(1);
    end
    chk("b_90", score_b, 8'h90);
    hit(1, 4'd5); wait_idle(1); pulse_miss(1);
    chk("b_95", score_b, 8'h95);
    chk("b_ovf0", ovf_b, 0);
    hit(1, 4'd7); wait_idle(1);
    chk("b_sat", score_b, 8'h99);
    chk("b_ovf1", ovf_b, 1);
    hit(1, 4'd1); wait_idle(1);
    chk("b_sat2", score_b, 8'h99);
    chk("b_ovf2", ovf_b, 1);
    chk("b_high", high_b, 8'h99);
    pulse_clr(1);
    chk("b_clr_ovf", ovf_b, 0);
    chk("b_clr_score", score_b, 0);
    chk("b_clr_high", high_b, 8'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
